// File: rtl/junction_controller.sv
// Two-road junction sequencer (NS/EW) with all-red clearance and registered lamp outputs.
// Define PED_CROSSING_EN to add the pedestrian WALK phase and the request latch.
module junction_controller #(
    parameter int GREEN_TICKS  = 8,
    parameter int AMBER_TICKS  = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 6,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ped_req,
    output logic ns_red,
    output logic ns_amber,
    output logic ns_green,
    output logic ew_red,
    output logic ew_amber,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);

    typedef enum logic [3:0] {
        ALLRED_A = 4'd0,
        NS_RA    = 4'd1,
        NS_G     = 4'd2,
        NS_A     = 4'd3,
        ALLRED_B = 4'd4,
        EW_RA    = 4'd5,
        EW_G     = 4'd6,
        EW_A     = 4'd7
`ifdef PED_CROSSING_EN
        , WALK   = 4'd8
`endif
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Lamp word: {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk}
    function automatic logic [6:0] lamp_decode(input state_t s);
        case (s)
            NS_RA:   lamp_decode = 7'b110_100_0;
            NS_G:    lamp_decode = 7'b001_100_0;
            NS_A:    lamp_decode = 7'b010_100_0;
            EW_RA:   lamp_decode = 7'b100_110_0;
            EW_G:    lamp_decode = 7'b100_001_0;
            EW_A:    lamp_decode = 7'b100_010_0;
`ifdef PED_CROSSING_EN
            WALK:    lamp_decode = 7'b100_100_1;
`endif
            default: lamp_decode = 7'b100_100_0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dwell_last(input state_t s);
        case (s)
            NS_RA, NS_A, EW_RA, EW_A: dwell_last = CNT_W'(AMBER_TICKS - 1);
            NS_G, EW_G:               dwell_last = CNT_W'(GREEN_TICKS - 1);
`ifdef PED_CROSSING_EN
            WALK:                     dwell_last = CNT_W'(WALK_TICKS - 1);
`endif
            default:                  dwell_last = CNT_W'(ALLRED_TICKS - 1);
        endcase
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] timer_r;
    logic [6:0]       lamps_r;
    logic             expire_s;
`ifdef PED_CROSSING_EN
    logic             ped_pending_r;
    logic             walk_to_ew_r;
    logic             enter_walk_s;
`endif

    // Next-state selection, evaluated only when the current dwell expires
    always_comb begin
        next_state_s = state_r;
        expire_s     = enable && (timer_r == dwell_last(state_r));
`ifdef PED_CROSSING_EN
        enter_walk_s = 1'b0;
`endif
        if (expire_s) begin
            case (state_r)
                ALLRED_A: next_state_s = NS_RA;
                NS_RA:    next_state_s = NS_G;
                NS_G:     next_state_s = NS_A;
                NS_A:     next_state_s = ALLRED_B;
                ALLRED_B: next_state_s = EW_RA;
                EW_RA:    next_state_s = EW_G;
                EW_G:     next_state_s = EW_A;
                EW_A:     next_state_s = ALLRED_A;
`ifdef PED_CROSSING_EN
                WALK:     next_state_s = walk_to_ew_r ? EW_RA : NS_RA;
`endif
                default:  next_state_s = ALLRED_A;
            endcase
`ifdef PED_CROSSING_EN
            // Pedestrians are only served from a clearance state, with both roads already red
            if (ped_pending_r && (state_r == ALLRED_A || state_r == ALLRED_B)) begin
                next_state_s = WALK;
                enter_walk_s = 1'b1;
            end else begin
                enter_walk_s = 1'b0;
            end
`endif
        end else begin
            next_state_s = state_r;
        end
    end

    // Phase FSM, dwell timer and lamp register updated together so lamps track state with no lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ALLRED_A;
            timer_r <= {CNT_W{1'b0}};
            lamps_r <= lamp_decode(ALLRED_A);
        end else if (expire_s) begin
            state_r <= next_state_s;
            timer_r <= {CNT_W{1'b0}};
            lamps_r <= lamp_decode(next_state_s);
        end else if (enable) begin
            timer_r <= timer_r + TIMER_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

`ifdef PED_CROSSING_EN
    // Request latch; the WALK entry edge clears it and wins over a simultaneous press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending_r <= 1'b0;
            walk_to_ew_r  <= 1'b0;
        end else if (enter_walk_s) begin
            ped_pending_r <= 1'b0;
            walk_to_ew_r  <= (state_r == ALLRED_B);
        end else if (ped_req && (state_r != WALK)) begin
            ped_pending_r <= 1'b1;
        end else begin
            ped_pending_r <= ped_pending_r;
        end
    end

    assign ped_pending = ped_pending_r;
`else
    logic unused_ped_s;
    assign unused_ped_s = ped_req;
    assign ped_pending  = 1'b0;
`endif

    assign ns_red   = lamps_r[6];
    assign ns_amber = lamps_r[5];
    assign ns_green = lamps_r[4];
    assign ew_red   = lamps_r[3];
    assign ew_amber = lamps_r[2];
    assign ew_green = lamps_r[1];
    assign walk     = lamps_r[0];

endmodule

// File: tb/tb_junction_controller.sv
// Bench for junction_controller: phase-schedule reference model, directed timing points, random soak.
module tb_junction_controller;
    localparam int GREEN = 8, AMBER = 2, ALLRED = 1, WALKT = 6;

    // {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_pending}
    localparam logic [7:0] O_ALLRED = 8'b1001_0000;
    localparam logic [7:0] O_NSRA   = 8'b1101_0000;
    localparam logic [7:0] O_NSG    = 8'b0011_0000;
    localparam logic [7:0] O_NSA    = 8'b0101_0000;
    localparam logic [7:0] O_EWRA   = 8'b1001_1000;
    localparam logic [7:0] O_EWG    = 8'b1000_0100;
    localparam logic [7:0] O_EWA    = 8'b1000_1000;
    localparam logic [7:0] O_WALK   = 8'b1001_0010;
    localparam logic [7:0] PEND     = 8'b0000_0001;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, ped_req = 1'b0;
    logic ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_pending;
    logic [7:0] dut_o;
    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    junction_controller #(
        .GREEN_TICKS(GREEN), .AMBER_TICKS(AMBER), .ALLRED_TICKS(ALLRED),
        .WALK_TICKS(WALKT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req),
        .ns_red(ns_red), .ns_amber(ns_amber), .ns_green(ns_green),
        .ew_red(ew_red), .ew_amber(ew_amber), .ew_green(ew_green),
        .walk(walk), .ped_pending(ped_pending)
    );

    assign dut_o = {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_pending};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ring of phases 0..7 plus phase 8 for the walk, each lasting dur() enabled edges
    int m_phase = 0, m_elapsed = 0, m_ret = 1;
    bit m_pend = 1'b0;

    function automatic int dur(input int p);
        if (p == 0 || p == 4) return ALLRED;
        if (p == 2 || p == 6) return GREEN;
        if (p == 8) return WALKT;
        return AMBER;
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] v;
        case (m_phase)
            1: v = O_NSRA;
            2: v = O_NSG;
            3: v = O_NSA;
            5: v = O_EWRA;
            6: v = O_EWG;
            7: v = O_EWA;
            8: v = O_WALK;
            default: v = O_ALLRED;
        endcase
        v[0] = m_pend;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        int old_phase;
        bit entering_walk;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_pend = 1'b0; m_ret = 1;
        end else begin
            old_phase = m_phase;
            entering_walk = 1'b0;
            if (enable) begin
                m_elapsed++;
                if (m_elapsed == dur(m_phase)) begin
                    m_elapsed = 0;
                    if (m_phase == 8) m_phase = m_ret;
                    else if ((m_phase == 0 || m_phase == 4) && m_pend) begin
                        m_ret = m_phase + 1; m_phase = 8; entering_walk = 1'b1;
                    end else m_phase = (m_phase + 1) % 8;
                end
            end
`ifdef PED_CROSSING_EN
            if (entering_walk) m_pend = 1'b0;
            else if (ped_req && old_phase != 8) m_pend = 1'b1;
`endif
        end
    end

    // Every-cycle comparison against the model plus the lamp safety invariant
    always @(negedge clk) begin
        logic ns_only_red, ew_only_red, conflict;
        chk("model", dut_o, model_out());
        ns_only_red = ({ns_red, ns_amber, ns_green} == 3'b100);
        ew_only_red = ({ew_red, ew_amber, ew_green} == 3'b100);
        conflict    = (ns_amber | ns_green) & (ew_amber | ew_green);
        chk("safety", {7'd0, (ns_only_red | ew_only_red) & ~conflict}, 8'd1);
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        rst = 1'b1; enable = 1'b0; ped_req = 1'b0;
        #1;
        chk("reset_state", dut_o, O_ALLRED);
        repeat (cycles) @(negedge clk);
        rst = 1'b0; enable = 1'b1;
    endtask

    task automatic at(input int e, input int want, input logic [7:0] v, input string nm);
        if (e == want) chk(nm, dut_o, v);
    endtask

    initial begin
        int walks;
        logic prev_walk;

        // Base sequence and 26-cycle period
        do_reset(3);
        for (int e = 1; e <= 55; e++) begin
            @(posedge clk); #1;
            at(e, 1, O_NSRA, "seq_e1");     at(e, 2, O_NSRA, "seq_e2");
            at(e, 3, O_NSG, "seq_e3");      at(e, 10, O_NSG, "seq_e10");
            at(e, 11, O_NSA, "seq_e11");    at(e, 12, O_NSA, "seq_e12");
            at(e, 13, O_ALLRED, "seq_e13"); at(e, 14, O_EWRA, "seq_e14");
            at(e, 15, O_EWRA, "seq_e15");   at(e, 16, O_EWG, "seq_e16");
            at(e, 23, O_EWG, "seq_e23");    at(e, 24, O_EWA, "seq_e24");
            at(e, 25, O_EWA, "seq_e25");    at(e, 26, O_ALLRED, "seq_e26");
            at(e, 27, O_NSRA, "seq_e27");   at(e, 29, O_NSG, "seq_e29");
            at(e, 52, O_ALLRED, "seq_e52"); at(e, 53, O_NSRA, "seq_e53");
            @(negedge clk);
        end

        // Asynchronous reset between edges during NS_G
        do_reset(2);
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            if (e < 5) @(negedge clk);
        end
        chk("pre_rst_green", dut_o, O_NSG);
        #2; rst = 1'b1; #1;
        chk("async_rst", dut_o, O_ALLRED);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            at(e, 1, O_NSRA, "restart_e1"); at(e, 3, O_NSG, "restart_e3");
            @(negedge clk);
        end

        // Enable freeze for 5 cycles inside EW_G
        do_reset(2);
        for (int e = 1; e <= 32; e++) begin
            enable = !(e >= 19 && e <= 23);
            @(posedge clk); #1;
            at(e, 21, O_EWG, "freeze_e21"); at(e, 28, O_EWG, "freeze_e28");
            at(e, 29, O_EWA, "freeze_e29"); at(e, 31, O_ALLRED, "freeze_e31");
            @(negedge clk);
        end
        enable = 1'b1;

        // Single pedestrian pulse sampled at edge 6
        do_reset(2);
        for (int e = 1; e <= 22; e++) begin
            ped_req = (e == 6);
            @(posedge clk); #1;
            at(e, 5, O_NSG, "ped_e5");
`ifdef PED_CROSSING_EN
            at(e, 6, O_NSG | PEND, "ped_e6");   at(e, 13, O_ALLRED | PEND, "ped_e13");
            at(e, 14, O_WALK, "ped_e14");       at(e, 19, O_WALK, "ped_e19");
            at(e, 20, O_EWRA, "ped_e20");       at(e, 22, O_EWG, "ped_e22");
`else
            at(e, 6, O_NSG, "ped_e6");          at(e, 14, O_EWRA, "ped_e14");
            at(e, 20, O_EWG, "ped_e20");
`endif
            @(negedge clk);
        end
        ped_req = 1'b0;

        // Request collapse: three presses in NS_G, one during the walk
        do_reset(2);
        walks = 0; prev_walk = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            ped_req = (e == 4 || e == 6 || e == 8 || e == 16);
            @(posedge clk); #1;
            if (walk && !prev_walk) walks++;
            prev_walk = walk;
`ifdef PED_CROSSING_EN
            at(e, 15, O_WALK, "collapse_e15"); at(e, 17, O_WALK, "collapse_e17");
            at(e, 32, O_ALLRED, "collapse_e32"); at(e, 33, O_NSRA, "collapse_e33");
`else
            at(e, 14, O_EWRA, "collapse_e14"); at(e, 27, O_NSRA, "collapse_e27");
`endif
            @(negedge clk);
        end
        ped_req = 1'b0;
`ifdef PED_CROSSING_EN
        chk("walk_count", 8'(walks), 8'd1);
`else
        chk("walk_count", 8'(walks), 8'd0);
`endif

        // Random soak with occasional mid-cycle asynchronous reset
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            enable  = ($urandom_range(0, 7) != 0);
            ped_req = ($urandom_range(0, 11) == 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/junction_controller.md
# junction_controller

Two-road junction controller sequencing two `traffic_lights`-style red/amber/green lamp sets (north–south road NS, east–west road EW) with all-red clearance and an optional pedestrian walk phase. It sits above the lamp drivers in the Ex5 design: one Moore FSM plus one dwell timer, with the lamp outputs decoded from the registered state.

## Interface
- `GREEN_TICKS`, default 8: enabled cycles spent in each road's green state.
- `AMBER_TICKS`, default 2: enabled cycles in each amber state and in each red+amber state.
- `ALLRED_TICKS`, default 1: enabled cycles in each all-red clearance state.
- `WALK_TICKS`, default 6: enabled cycles in the pedestrian walk state.
- `CNT_W`, default 8: dwell timer width. Every `*_TICKS` value must lie in 1..2^CNT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, the state and timer hold.
- `ped_req`  in  1  pedestrian button, level or pulse.
- `ns_red`, `ns_amber`, `ns_green`  out  1 each  NS lamps.
- `ew_red`, `ew_amber`, `ew_green`  out  1 each  EW lamps.
- `walk`  out  1  pedestrian walk lamp.
- `ped_pending`  out  1  a pedestrian request is latched and not yet served.

## Operation
- States:
  - ALLRED_A
  - NS_RA
  - NS_G
  - NS_A
  - ALLRED_B
  - EW_RA
  - EW_G
  - EW_A
  - WALK (exists only with the macro)
- Base ring: ALLRED_A→NS_RA→NS_G→NS_A→ALLRED_B→EW_RA→EW_G→EW_A→ALLRED_A.
- Lamp decode per state; any lamp not listed is 0:
  - ALLRED_A, ALLRED_B, WALK: ns_red=1, ew_red=1.
  - NS_RA: ns_red=1, ns_amber=1, ew_red=1.
  - NS_G: ns_green=1, ew_red=1.
  - NS_A: ns_amber=1, ew_red=1.
  - EW_RA, EW_G, EW_A: mirror of the NS states, with ns_red=1.
  - walk=1 only in WALK.
- Safety invariant: at every cycle at least one road shows exactly red only. Green and amber are never lit on both roads.
- Dwell timer:
  - Cleared to 0 on every state entry.
  - Increments on each edge with enable=1.
  - The state advances on the edge where enable=1 and timer==TICKS−1.
  - Each state therefore lasts exactly TICKS enabled cycles.
- enable=0: state, timer and outputs hold. ped_req is still latched.
- Reset (asynchronous, takes effect immediately):
  - state ALLRED_A, timer 0.
  - ns_red=ew_red=1; all other lamps 0.
  - walk=0, ped_pending=0.
  - Reset applied mid-phase abandons that phase; no amber step is inserted.

## Timing
- Edge 1 is the first rising edge with rst=0 and enable=1. Default transitions, without pedestrian service:
  - NS_RA@1
  - NS_G@3
  - NS_A@11
  - ALLRED_B@13
  - EW_RA@14
  - EW_G@16
  - EW_A@24
  - ALLRED_A@26
  - NS_RA@27
- Period is 2·ALLRED_TICKS + 2·(2·AMBER_TICKS + GREEN_TICKS) = 26 cycles.
- Outputs change on the same edge that updates the state register, with no extra latency.
- ped_pending:
  - Set on the edge where ped_req=1 and the state is not WALK.
  - Cleared on the edge that enters WALK.
  - ped_req sampled on that entry edge, or during WALK, is ignored.
  - Multiple requests before service collapse into one.
- When an ALLRED state expires with ped_pending=1, the next state is WALK instead of the next road's RA state. WALK then proceeds to that road's RA:
  - From ALLRED_B, WALK is followed by EW_RA.
  - From ALLRED_A, WALK is followed by NS_RA.

## Configuration
- `PED_CROSSING_EN` defined:
  - WALK state, ped_pending latch and walk decode are present, as described above.
- `PED_CROSSING_EN` undefined:
  - No WALK state; ped_req is ignored.
  - walk and ped_pending are tied to 0; the ports remain present.
  - The ring is always the base 26-cycle ring.

## Test plan
- Reset and sequence: hold rst for 3 cycles, release, enable=1. Require the transitions at edges 1, 3, 11, 13, 14, 16, 24, 26 and 27 with the lamp values above, and a 26-cycle period.
- Async reset mid-green: raise rst between edges during NS_G. Require ns_red=ew_red=1 and ns_green=0 before the next clock edge, and a restart at NS_RA on edge 1 after release.
- Enable freeze: drop enable for 5 cycles inside EW_G. Require the lamps to hold, EW_G to total 8 enabled cycles, and EW_A to arrive at edge 29.
- Pedestrian request (macro on): 1-cycle ped_req pulse at edge 5. Require:
  - ped_pending=1 from edge 6.
  - WALK at edge 14 with walk=1 and both roads red, and ped_pending=0 from edge 14.
  - EW_RA at edge 20.
- Request collapse: 3 pulses during NS_G plus 1 pulse during WALK. Require exactly one WALK in that round and ped_pending=0 after the WALK entry.
- Macro off: the same pulses as the pedestrian tests. Require walk=0, ped_pending=0 and an unchanged 26-cycle ring. The safety invariant is asserted continuously in every test.
